// File: rtl/parallel_to_serial_if.sv
// Handshake and serial-output bundle between a word source and the parallel_to_serial shifter.
interface parallel_to_serial_if #(
  parameter int max_width  = 16,
  parameter int width_bits = 5
);
  logic                  load;
  logic [width_bits-1:0] width;
  logic [max_width-1:0]  data;
  logic                  ready;
  logic                  out;
  logic                  out_valid;
  logic                  first;
  logic                  last;

  modport master (
    output load, width, data,
    input  ready, out, out_valid, first, last
  );

  modport slave (
    input  load, width, data,
    output ready, out, out_valid, first, last
  );
endinterface

// File: rtl/parallel_to_serial.sv
// LSB-first word serializer with a one-entry holding slot so consecutive words stream gap-free.
module parallel_to_serial #(
  parameter int max_width  = 16,
  parameter int width_bits = 5
) (
  input logic                  clock,
  input logic                  reset,
  parallel_to_serial_if.slave  bus
);

  localparam logic [width_bits-1:0] MAX_W = width_bits'(max_width);
  localparam logic [width_bits-1:0] ONE   = width_bits'(1);

  // 0 and oversize requests both mean a full-length word
  function automatic logic [width_bits-1:0] clamp_width(input logic [width_bits-1:0] w);
    if ((w == '0) || (w > MAX_W)) return MAX_W;
    return w;
  endfunction

  logic [max_width-1:0]  sh_word;
  logic [width_bits-1:0] sh_cnt;
  logic                  busy;
  logic [max_width-1:0]  hold_word;
  logic [width_bits-1:0] hold_width;
  logic                  hold_full;
  logic                  rdy_en;
  logic                  out_p0;
  logic                  vld_p0;
  logic                  first_p0;
  logic                  last_p0;

  logic                  ready;
  logic                  accept;
  logic                  finishing;
  logic [max_width-1:0]  shifted;
  logic [width_bits-1:0] eff_width;

  always_comb begin
    ready     = rdy_en & ~hold_full;
    accept    = bus.load & ready;
    finishing = busy & (sh_cnt == ONE);
    shifted   = sh_word >> 1;
    eff_width = clamp_width(bus.width);
  end

  // Output stage p0: registered bit presented during the cycle after each edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_word    <= '0;
      sh_cnt     <= '0;
      busy       <= 1'b0;
      hold_word  <= '0;
      hold_width <= '0;
      hold_full  <= 1'b0;
      rdy_en     <= 1'b0;
      out_p0     <= 1'b0;
      vld_p0     <= 1'b0;
      first_p0   <= 1'b0;
      last_p0    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (busy && !finishing) begin
        sh_word  <= shifted;
        sh_cnt   <= sh_cnt - ONE;
        out_p0   <= shifted[0];
        vld_p0   <= 1'b1;
        first_p0 <= 1'b0;
        last_p0  <= (sh_cnt == width_bits'(2));
        if (accept) begin
          hold_word  <= bus.data;
          hold_width <= eff_width;
          hold_full  <= 1'b1;
        end
      end else if (hold_full) begin
        // ready is low while the slot is full, so no acceptance can collide here
        sh_word   <= hold_word;
        sh_cnt    <= hold_width;
        busy      <= 1'b1;
        hold_full <= 1'b0;
        out_p0    <= hold_word[0];
        vld_p0    <= 1'b1;
        first_p0  <= 1'b1;
        last_p0   <= (hold_width == ONE);
      end else if (accept) begin
        sh_word  <= bus.data;
        sh_cnt   <= eff_width;
        busy     <= 1'b1;
        out_p0   <= bus.data[0];
        vld_p0   <= 1'b1;
        first_p0 <= 1'b1;
        last_p0  <= (eff_width == ONE);
      end else begin
        sh_cnt   <= '0;
        busy     <= 1'b0;
        out_p0   <= 1'b0;
        vld_p0   <= 1'b0;
        first_p0 <= 1'b0;
        last_p0  <= 1'b0;
      end
    end
  end

  assign bus.ready     = ready;
  assign bus.out       = out_p0;
  assign bus.out_valid = vld_p0;
  assign bus.first     = first_p0;
  assign bus.last      = last_p0;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Scoreboard bench: accepted words expand into timed expected bits; a monitor checks every cycle.
module tb_parallel_to_serial;

  localparam int MW = 16;
  localparam int WB = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;

  parallel_to_serial_if #(.max_width(MW), .width_bits(WB)) bus ();

  parallel_to_serial #(.max_width(MW), .width_bits(WB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    int cyc;
    bit b;
    bit f;
    bit l;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt  = 0;
  int   next_free = 0;
  bit   hold_act  = 0;
  int   hold_lo   = 0;
  int   hold_hi   = 0;
  int   rd_idx    = 0;
  int   nerr      = 0;
  int   nchk      = 0;
  bit   done      = 0;
  bit   end_chk   = 0;

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", nm, edge_cnt, act, req);
    end
  endtask

  // Reference model: each accepted word occupies the next free run of cycles
  initial begin
    int w;
    int start;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        edge_cnt  = 0;
        next_free = 0;
        hold_act  = 0;
      end else begin
        edge_cnt++;
        if (bus.load && bus.ready) begin
          w     = int'(bus.width);
          if (w == 0 || w > MW) w = MW;
          start = (next_free > edge_cnt) ? next_free : edge_cnt;
          for (int i = 0; i < w; i++) begin
            exp_t e;
            e.cyc = start + i;
            e.b   = bus.data[i];
            e.f   = (i == 0);
            e.l   = (i == w - 1);
            exp_q.push_back(e);
          end
          if (start > edge_cnt) begin
            hold_act = 1;
            hold_lo  = edge_cnt;
            hold_hi  = start - 1;
          end
          next_free = start + w;
        end
      end
    end
  end

  // Monitor
  initial begin
    logic [4:0] act;
    logic       exp_rdy;
    exp_t       e;
    forever begin
      @(negedge clock or negedge reset);
      #1;
      act = {bus.out_valid, bus.out, bus.first, bus.last, bus.ready};
      if (!reset) begin
        rd_idx = exp_q.size();
        check("reset_outputs", act, 5'b0);
      end else begin
        if (rd_idx < exp_q.size() && exp_q[rd_idx].cyc == edge_cnt) begin
          e = exp_q[rd_idx];
          rd_idx++;
          check("bit", {act[4:1], 1'b0}, {1'b1, e.b, e.f, e.l, 1'b0});
        end else begin
          check("idle", {act[4:1], 1'b0}, 5'b0);
        end
        exp_rdy = (edge_cnt >= 1) &&
                  !(hold_act && edge_cnt >= hold_lo && edge_cnt <= hold_hi);
        check("ready", {4'b0, bus.ready}, {4'b0, exp_rdy});
        if (done && !end_chk) begin
          end_chk = 1;
          check("drained", {4'b0, rd_idx == exp_q.size()}, 5'b00001);
        end
      end
    end
  end

  task automatic send(input logic [WB-1:0] w, input logic [MW-1:0] d);
    int t;
    bus.load  = 1'b1;
    bus.width = w;
    bus.data  = d;
    t = 0;
    while (!bus.ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!bus.ready) begin
      $display("FAIL accept_timeout width=%0d data=%h", w, d);
      $fatal(1, "ready never asserted");
    end
    @(negedge clock);
    bus.load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    bus.load  = 1'b0;
    bus.width = '0;
    bus.data  = '0;
    idle(3);
    reset = 1'b1;
    idle(3);

    send(5'd4, 16'h000A);
    idle(6);

    send(5'd3, 16'h0005);
    send(5'd2, 16'h0002);
    idle(8);

    send(5'd8, 16'h0001);
    send(5'd8, 16'h0002);
    send(5'd8, 16'h0003);
    idle(30);

    for (int i = 0; i < 12; i++) send(5'd1, ((i % 2) == 0) ? 16'h0001 : 16'h0000);
    idle(4);

    send(5'd0, 16'hFFFF);
    send(5'd31, 16'h0001);
    idle(40);

    for (int i = 0; i < 30; i++) begin
      send(5'($urandom_range(0, 31)), 16'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(40);

    send(5'd8, 16'($urandom));
    send(5'd8, 16'($urandom));
    @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(20);

    send(5'd5, 16'h0013);
    idle(10);

    done = 1;
    idle(3);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

Transmit-side counterpart of the serial deserializer: accepts a parallel word of programmable bit count and shifts it out LSB-first, one bit per clock. It feeds the serial bit stream that the deserializer reassembles. A one-entry holding register lets the next word be queued while the current word is still shifting, so consecutive words stream with no idle cycle between them.

## Interface
- `max_width`, default 16: maximum word length in bits, from 1 to 64.
- `width_bits`, default 5: width of the `width` port; must satisfy 2^width_bits > max_width.
- `reset` input, 1 bit: asynchronous, active-low reset. Fixed: one clock, async active-low reset.
- `clock` input, 1 bit: all state changes on the rising edge.
- `width` input, [width_bits-1:0]: bit count of the offered word. 0 or any value > max_width is treated as max_width.
- `data` input, [max_width-1:0]: word offered for transmission. Bit 0 is sent first.
- `load` input, 1 bit: offer request. A word is accepted on a rising edge where load=1 and ready=1.
- `ready` output, 1 bit: the block can accept a word this cycle.
- `out` output, 1 bit: serial data bit.
- `out_valid` output, 1 bit: `out` carries a valid bit this cycle.
- `first` output, 1 bit: the current bit is bit 0 of a word.
- `last` output, 1 bit: the current bit is the final bit of a word.

## Operation
- State consists of:
  - a shifter: word register, remaining-bit counter, and busy flag;
  - a holding slot: word, width, and full flag;
  - a ready-enable flag.
- Reset (reset=0) takes effect immediately. It clears the shifter, the holding slot, out, out_valid, first, last and ready-enable. Any accepted but untransmitted bits are discarded.
- ready = ready-enable AND NOT holding-full.
  - ready-enable sets on the first rising edge with reset=1, so ready is 0 for that first cycle after release.
- Shifter "finishing" means busy with a remaining count of 1.
- On each rising edge (reset=1), priority is as follows:
  - Shifter busy and not finishing: shift right by one and decrement the remaining count. The new LSB drives `out` on the next cycle.
  - Shifter finishing or idle, holding slot full: move the holding word into the shifter with the count set to its width. The slot empties.
  - Shifter finishing or idle, holding slot empty, word accepted this edge: load the accepted word directly into the shifter.
  - Shifter finishing or idle, nothing available: the shifter goes idle.
  - Word accepted while the shifter stays busy (not finishing): the word goes into the holding slot.
- Width arithmetic: the effective width is resolved at acceptance and stored with the word. Bits of `data` above the effective width are ignored.
- Output registers are set on the same edge that presents bit k of the word:
  - out = bit k;
  - out_valid = 1;
  - first = (k==0);
  - last = (k==effective width−1).
- When no bit is presented, out, out_valid, first and last are all 0.
- A 1-bit word asserts first and last together.
- `load` while ready=0 is ignored and has no side effects. The offerer must hold the word until it is accepted.

## Timing
- Latency: word accepted at edge N into an idle shifter → bit 0 on `out` during cycle N+1 (registered output).
- Throughput: one bit per clock. A word of width W occupies out_valid for exactly W consecutive cycles.
- Back-to-back: if the next word is held or accepted no later than the edge that ends the previous word's last bit, its bit 0 follows the previous word's last bit with no gap.
- ready falls in the cycle after a word enters the holding slot. It rises in the cycle after the slot empties.
- Because moving the holding word into the shifter and accepting a new word can happen on the same edge only if the slot was empty, the holding slot never overflows.

## Test plan
- Single word:
  - Stimulus: release reset, wait for ready, then load width=4, data=0x000A for one cycle.
  - Required response: out_valid for 4 cycles, out = 0,1,0,1, first on cycle 1 only, last on cycle 4 only, then all outputs 0.
- Back-to-back streaming:
  - Stimulus: load width=3, data=0x5; next cycle load width=2, data=0x2.
  - Required response: 5 contiguous valid bits 1,0,1,0,1; first on bits 1 and 4; last on bits 3 and 5; ready low for exactly the cycles the slot is full.
- Backpressure:
  - Stimulus: hold load=1 with width=8 words 0x01, 0x02, 0x03 on consecutive acceptances.
  - Required response: third word accepted only when the first word's last bit leaves the shifter; 24 contiguous valid bits in order.
- Width 1 continuous:
  - Stimulus: load=1 every cycle, width=1, data alternating 1/0.
  - Required response: out_valid held at 1, out alternating, first=last=1 every cycle, ready never deasserts.
- Width clamp:
  - Stimulus: width=0, data=0xFFFF, then width=31, data=0x0001.
  - Required response: first word gives 16 valid ones; second word gives 16 bits (1 then fifteen 0s) with last on the 16th bit.
- Reset mid-word:
  - Stimulus: assert reset=0 asynchronously during bit 3 of a width=8 word, with the holding slot full.
  - Required response: out, out_valid, first, last and ready go to 0 immediately; after release, ready is 0 for one cycle, then 1; no residual bits appear.
